// File: rtl/bht_controller.sv
// Branch history table controller: 2-bit saturating counters with init sweep, 1-cycle lookups and FIFO-buffered updates.
// Optional statistics counters are enabled with `define PRED_STATS_EN.
module bht_controller #(
    parameter int IDX_W      = 6,
    parameter int UPD_DEPTH  = 4,
    parameter int INIT_STATE = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lookup_valid,
    input  logic [IDX_W-1:0]             lookup_idx,
    output logic                         pred_valid,
    output logic                         pred_taken,
    output logic                         pred_strong,
    input  logic                         upd_valid,
    input  logic [IDX_W-1:0]             upd_idx,
    input  logic                         upd_taken,
`ifdef PRED_STATS_EN
    input  logic                         upd_pred,
    output logic [31:0]                  stat_lookups,
    output logic [31:0]                  stat_updates,
    output logic [31:0]                  stat_mispredicts,
`endif
    output logic                         upd_ready,
    output logic                         init_done,
    output logic [$clog2(UPD_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(UPD_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [1:0]       INIT_VAL = INIT_STATE[1:0];
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(UPD_DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] init_ptr;

    logic [1:0]       table_mem [ENTRIES];
    logic [IDX_W-1:0] fifo_idx   [UPD_DEPTH];
    logic             fifo_taken [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic             push, pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic [1:0]       head_ctr, head_next, lookup_ctr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        init_done  = 1'b0;
        upd_ready  = 1'b0;
        case (state)
            S_INIT: if (init_ptr == '1) state_next = S_RUN;
            S_RUN: begin
                init_done = 1'b1;
                upd_ready = (fifo_count != FULL);
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 init_ptr <= '0;
        else if (state == S_INIT) init_ptr <= init_ptr + IDX_W'(1);
    end

    assign push = upd_valid && upd_ready;
    assign pop  = (state == S_RUN) && (fifo_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]   <= upd_idx;
            fifo_taken[wr_ptr] <= upd_taken;
        end
    end

    assign head_idx   = fifo_idx[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];
    assign head_ctr   = table_mem[head_idx];

    always_comb begin
        head_next = head_ctr;
        if (head_taken) begin
            if (head_ctr != 2'd3) head_next = head_ctr + 2'd1;
        end else begin
            if (head_ctr != 2'd0) head_next = head_ctr - 2'd1;
        end
    end

    // Single write port: init sweep owns it during INIT, the drain owns it in RUN.
    always_ff @(posedge clk) begin
        if (state == S_INIT) table_mem[init_ptr] <= INIT_VAL;
        else if (pop)        table_mem[head_idx] <= head_next;
    end

    assign lookup_ctr = (state == S_INIT) ? INIT_VAL : table_mem[lookup_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_strong <= 1'b0;
        end else begin
            pred_valid <= lookup_valid;
            if (lookup_valid) begin
                pred_taken  <= lookup_ctr[1];
                pred_strong <= (lookup_ctr == 2'd0) || (lookup_ctr == 2'd3);
            end
        end
    end

`ifdef PRED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (lookup_valid && state == S_RUN) stat_lookups <= stat_lookups + 32'd1;
            if (push)                           stat_updates <= stat_updates + 32'd1;
            if (push && (upd_pred != upd_taken)) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/bht_controller.md
Name: bht_controller

Overview:
- Owns a table of 2^IDX_W two-bit saturating branch counters and schedules access to it.
- Two requesters share the table: fetch-side lookups (read port, 1-cycle latency) and resolve-side outcome updates (buffered in an update FIFO, drained one per cycle into the single table write port).
- After reset, an init sequencer sweeps the table to INIT_STATE before updates are accepted.

Parameters:
- IDX_W, 6, table index width; table has 2^IDX_W entries.
- UPD_DEPTH, 4, update FIFO depth; power of two, >= 2.
- INIT_STATE, 3, 2-bit counter value written to every entry during init (3 = strongly taken).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lookup_valid  input  1  lookup request this cycle.
- lookup_idx  input  IDX_W  table index to read.
- pred_valid  output  1  prediction valid; registered, one cycle after lookup_valid.
- pred_taken  output  1  bit 1 of the counter read.
- pred_strong  output  1  1 when the counter read is 0 or 3.
- upd_valid  input  1  resolved-branch outcome offered.
- upd_idx  input  IDX_W  index to update.
- upd_taken  input  1  actual branch outcome.
- upd_ready  output  1  FIFO accepts; transfer occurs when upd_valid && upd_ready.
- init_done  output  1  high once the init sweep completes.
- fifo_count  output  clog2(UPD_DEPTH)+1  current update FIFO occupancy.

Behaviour:
- Reset values: pred_valid=0, pred_taken=0, pred_strong=0, upd_ready=0, init_done=0, fifo_count=0. FSM enters INIT with init pointer=0. Table contents are not reset directly.
- FSM INIT:
  - Each cycle, write INIT_STATE to entry[ptr], then ptr+1.
  - After writing entry 2^IDX_W-1, go to RUN; init_done rises on that transition (2^IDX_W cycles after reset deassert).
  - upd_ready=0 throughout INIT.
- FSM RUN:
  - upd_ready = (fifo_count != UPD_DEPTH).
  - Stays in RUN until rst.
- Lookups:
  - Accepted in every state.
  - On lookup_valid at cycle N, pred_valid=1 at N+1 with the counter value at edge N. If no lookup at N, pred_valid=0 at N+1.
  - During INIT, lookups return pred_taken=INIT_STATE[1] and pred_strong derived from INIT_STATE, regardless of table contents.
- Update FIFO:
  - Push when upd_valid && upd_ready. Pop when in RUN and non-empty.
  - Push and pop in the same cycle: count unchanged. A push into an empty FIFO is popped no earlier than the next cycle.
  - Pointers wrap modulo UPD_DEPTH.
- Drain: a popped entry does a read-modify-write of the table in that cycle.
  - taken: counter+1, saturating at 3.
  - not taken: counter-1, saturating at 0.
  - Applied updates are strictly in FIFO order.
- Same-index conflict: a lookup and a drain-write to the same index in the same cycle return the old (pre-update) value. There is no forwarding of queued updates.
- Reset mid-operation: rst asserted at any time clears FIFO pointers (queued updates are discarded), forces outputs to reset values, and restarts INIT from ptr=0.

Optional Feature:
- Macro: PRED_STATS_EN.
- When defined, adds:
  - input upd_pred (1 bit; the prediction that was used, sampled with each update push).
  - 32-bit outputs stat_lookups, stat_updates, stat_mispredicts, all reset to 0 and wrapping at 2^32.
  - stat_lookups increments per accepted lookup in RUN.
  - stat_updates increments per FIFO push.
  - stat_mispredicts increments per push with upd_pred != upd_taken.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Release rst, IDX_W=6 -> init_done=0 and upd_ready=0 for 64 cycles, then init_done=1; a lookup of idx 5 gives pred_taken=1, pred_strong=1.
- Two not-taken updates to idx 9 after init, then lookup idx 9 once the FIFO is empty -> counter goes 3→2→1; pred_taken=0, pred_strong=0. A third not-taken update then a lookup -> counter 0, pred_strong=1. A fourth -> stays 0.
- Hold lookup_valid continuously while pushing 4 back-to-back updates (UPD_DEPTH=4) with the drain running -> fifo_count never exceeds 4; upd_ready drops only when fifo_count=4; all 4 updates are applied in order.
- Same cycle: drain-write to idx 12 (taken, counter 1→2) and lookup idx 12 -> pred_taken=0 (old value); a lookup the next cycle -> pred_taken=1.
- Assert rst with 3 updates queued mid-run -> fifo_count=0 immediately; INIT restarts; after 64 cycles, idx 9 reads back as 3.
- With PRED_STATS_EN defined: 10 lookups, 4 updates of which 2 have upd_pred != upd_taken -> stat_lookups=10, stat_updates=4, stat_mispredicts=2.
